// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEST_W_DEF = 5;

   // Data-memory access sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem2wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and
// leaves the data fields holding; load data only updates on a load return.
module mem2wb_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_bubble,
   input  logic              i_wb_en,
   input  logic              i_mem_to_reg,
   input  logic [DATA_W-1:0] i_alu_res,
   input  logic              i_ld_data_en,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic [DEST_W-1:0] i_dest,
   output logic              o_wb_en,
   output logic              o_mem_to_reg,
   output logic [DATA_W-1:0] o_alu_res,
   output logic [DATA_W-1:0] o_mem_data,
   output logic [DEST_W-1:0] o_dest
);

   logic              r_wb_en;
   logic              r_mem_to_reg;
   logic [DATA_W-1:0] r_alu_res;
   logic [DATA_W-1:0] r_mem_data;
   logic [DEST_W-1:0] r_dest;

   // Capture the stage result, or insert a bubble while the stage is not done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_en      <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_alu_res    <= '0;
         r_mem_data   <= '0;
         r_dest       <= '0;
      end else if (i_bubble) begin
         r_wb_en      <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else begin
         r_wb_en      <= i_wb_en;
         r_mem_to_reg <= i_mem_to_reg;
         r_alu_res    <= i_alu_res;
         r_dest       <= i_dest;
         if (i_ld_data_en) r_mem_data <= i_ld_data;
      end
   end

   assign o_wb_en      = r_wb_en;
   assign o_mem_to_reg = r_mem_to_reg;
   assign o_alu_res    = r_alu_res;
   assign o_mem_data   = r_mem_data;
   assign o_dest       = r_dest;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/gnt/rvalid data bus, stalls the front of the
// pipeline while an access is outstanding, resolves the branch and owns
// the MEM/WB register.
// Optional: define MEM_MISALIGN_CHK_EN to block word-misaligned accesses
// and expose a sticky misalign_err flag.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEST_W = DEST_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              zero_in,
   input  logic              branch_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] st_val_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              pc_src,
   output logic              wb_en,
   output logic              mem_to_reg,
   output logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] mem_data,
`ifdef MEM_MISALIGN_CHK_EN
   output logic              misalign_err,
`endif
   output logic [DEST_W-1:0] dest
);

   mem_state_e r_state;
   logic       w_op;
   logic       w_is_st;
   logic       w_misalign;
   logic       w_req;
   logic       w_st_done;
   logic       w_ld_done;
   logic       w_complete;
   logic       w_bubble;

   // Both enables set is treated as a store
   assign w_op    = mem_r_en_in | mem_w_en_in;
   assign w_is_st = mem_w_en_in;

`ifdef MEM_MISALIGN_CHK_EN
   logic r_misalign_err;

   // Misalignment is judged only when a new access would be launched
   assign w_misalign = (r_state == IDLE) & w_op & (alu_res_in[1:0] != 2'b00);

   // Sticky error flag, set by the first blocked access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            r_misalign_err <= 1'b0;
      else if (w_misalign) r_misalign_err <= 1'b1;
   end

   assign misalign_err = r_misalign_err;
`else
   assign w_misalign = 1'b0;
`endif

   // Request is combinational in IDLE and held through REQ; reset drops it at once
   assign w_req = rst & (((r_state == IDLE) & w_op & ~w_misalign) | (r_state == REQ));

   // A store finishes on grant; a load only on rvalid once the grant is behind us
   assign w_st_done  = w_req & dmem_gnt & w_is_st;
   assign w_ld_done  = (r_state == WAIT_R) & dmem_rvalid;
   assign w_complete = w_st_done | w_ld_done | w_misalign;
   assign stall      = w_op & ~w_complete;
   assign w_bubble   = stall | w_misalign;

   // Access sequencer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_op && !w_misalign) begin
                  if (dmem_gnt) r_state <= w_is_st ? IDLE : WAIT_R;
                  else          r_state <= REQ;
               end
            end
            REQ: begin
               if (dmem_gnt) r_state <= w_is_st ? IDLE : WAIT_R;
            end
            WAIT_R: begin
               if (dmem_rvalid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Bus fields come straight from EX/MEM, which upstream holds during a stall
   assign dmem_req   = w_req;
   assign dmem_we    = mem_w_en_in;
   assign dmem_addr  = alu_res_in;
   assign dmem_wdata = st_val_in;

   assign pc_src = zero_in & branch_in;

   mem2wb_reg #(
      .DATA_W (DATA_W),
      .DEST_W (DEST_W)
   ) u_mem2wb (
      .clk          (clk),
      .rst_n        (rst),
      .i_bubble     (w_bubble),
      .i_wb_en      (wb_en_in),
      .i_mem_to_reg (w_ld_done),
      .i_alu_res    (alu_res_in),
      .i_ld_data_en (w_ld_done),
      .i_ld_data    (dmem_rdata),
      .i_dest       (dest_in),
      .o_wb_en      (wb_en),
      .o_mem_to_reg (mem_to_reg),
      .o_alu_res    (alu_res),
      .o_mem_data   (mem_data),
      .o_dest       (dest)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected write-backs are queued
// when an instruction is driven and matched when wb_en rises out of MEM/WB.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, zero_in, branch_in;
   logic [31:0] alu_res_in, st_val_in;
   logic [4:0]  dest_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall, pc_src, wb_en, mem_to_reg;
   logic [31:0] alu_res, mem_data;
   logic [4:0]  dest;
`ifdef MEM_MISALIGN_CHK_EN
   logic        misalign_err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [4:0]  dest;
      logic        m2r;
   } wb_t;

   wb_t sb_q[$];
   wb_t mon_e;

   mem_access_stage dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .zero_in(zero_in), .branch_in(branch_in),
      .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall(stall), .pc_src(pc_src), .wb_en(wb_en), .mem_to_reg(mem_to_reg),
      .alu_res(alu_res), .mem_data(mem_data),
`ifdef MEM_MISALIGN_CHK_EN
      .misalign_err(misalign_err),
`endif
      .dest(dest)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Scoreboard: every write-back leaving MEM/WB must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_en === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got alu_res=%h dest=%0d mem_to_reg=%b, expected no write-back",
                     alu_res, dest, mem_to_reg);
         end else begin
            mon_e = sb_q.pop_front();
            if (alu_res !== mon_e.alu || dest !== mon_e.dest || mem_to_reg !== mon_e.m2r ||
                (mon_e.m2r && mem_data !== mon_e.mdata)) begin
               errors++;
               $display("FAIL wb_record: got alu=%h dest=%0d m2r=%b mdata=%h, expected alu=%h dest=%0d m2r=%b mdata=%h",
                        alu_res, dest, mem_to_reg, mem_data, mon_e.alu, mon_e.dest, mon_e.m2r, mon_e.mdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; zero_in = 0; branch_in = 0;
      alu_res_in = 0; st_val_in = 0; dest_in = 0;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if (wb_en !== 1'b0 || mem_to_reg !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: wb_en=%b mem_to_reg=%b, expected 0 0", wb_en, mem_to_reg);
      end
      checks++;
      if (alu_res !== 32'h0 || mem_data !== 32'h0 || dest !== 5'h0) begin
         errors++; $display("FAIL reset_data: alu_res=%h mem_data=%h dest=%0d, expected 0", alu_res, mem_data, dest);
      end
      checks++;
      if (dmem_req !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL reset_bus: dmem_req=%b stall=%b, expected 0 0", dmem_req, stall);
      end
`ifdef MEM_MISALIGN_CHK_EN
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL reset_misalign: misalign_err=%b, expected 0", misalign_err);
      end
`endif
      tick();
      rst = 1;
   endtask

   task automatic test_alu();
      tick();
      wb_en_in = 1; alu_res_in = 32'h10; dest_in = 5'd3;
      sb_q.push_back('{alu: 32'h10, mdata: 32'h0, dest: 5'd3, m2r: 1'b0});
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL alu_bus: stall=%b dmem_req=%b, expected 0 0", stall, dmem_req);
      end
      tick();
      clear_inputs();
      checks++;
      if (wb_en !== 1'b1 || alu_res !== 32'h10 || dest !== 5'd3 || mem_to_reg !== 1'b0) begin
         errors++; $display("FAIL alu_wb: wb_en=%b alu_res=%h dest=%0d m2r=%b, expected 1 10 3 0",
                            wb_en, alu_res, dest, mem_to_reg);
      end
   endtask

   task automatic test_store_fast();
      tick();
      mem_w_en_in = 1; alu_res_in = 32'h40; st_val_in = 32'hDEADBEEF; dmem_gnt = 1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h40 || dmem_wdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h, expected 1 1 40 deadbeef",
                            dmem_req, dmem_we, dmem_addr, dmem_wdata);
      end
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL store_stall: stall=%b, expected 0", stall);
      end
      tick();
      clear_inputs();
      checks++;
      if (wb_en !== 1'b0) begin
         errors++; $display("FAIL store_wb: wb_en=%b, expected 0", wb_en);
      end
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++; $display("FAIL store_req_drop: dmem_req=%b, expected 0", dmem_req);
      end
   endtask

   // Both enables set, grant one cycle late: must behave as a store
   task automatic test_store_wait();
      tick();
      mem_r_en_in = 1; mem_w_en_in = 1; wb_en_in = 1;
      alu_res_in = 32'h44; st_val_in = 32'hCAFEF00D; dest_in = 5'd9; dmem_gnt = 0;
      sb_q.push_back('{alu: 32'h44, mdata: 32'h0, dest: 5'd9, m2r: 1'b0});
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall !== 1'b1) begin
         errors++; $display("FAIL rw_wait: req=%b we=%b stall=%b, expected 1 1 1", dmem_req, dmem_we, stall);
      end
      tick();
      checks++;
      if (wb_en !== 1'b0) begin
         errors++; $display("FAIL rw_bubble: wb_en=%b, expected 0", wb_en);
      end
      dmem_gnt = 1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h44 || dmem_wdata !== 32'hCAFEF00D || stall !== 1'b0) begin
         errors++; $display("FAIL rw_grant: req=%b addr=%h wdata=%h stall=%b, expected 1 44 cafef00d 0",
                            dmem_req, dmem_addr, dmem_wdata, stall);
      end
      tick();
      clear_inputs();
      checks++;
      if (wb_en !== 1'b1 || mem_to_reg !== 1'b0) begin
         errors++; $display("FAIL rw_wb: wb_en=%b mem_to_reg=%b, expected 1 0", wb_en, mem_to_reg);
      end
   endtask

   // Grant on cycle 2 (with a stray rvalid that must be ignored), rvalid on cycle 5
   task automatic test_load_delayed();
      int stall_cnt = 0;
      bit done = 0;
      tick();
      mem_r_en_in = 1; wb_en_in = 1; alu_res_in = 32'h80; dest_in = 5'd7;
      sb_q.push_back('{alu: 32'h80, mdata: 32'h1234, dest: 5'd7, m2r: 1'b1});
      for (int c = 0; c < 20 && !done; c++) begin
         dmem_gnt    = (c == 2);
         dmem_rvalid = (c == 2) || (c == 5);
         dmem_rdata  = (c == 5) ? 32'h1234 : 32'hBAD0BAD0;
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h80) begin
               errors++; $display("FAIL load_req: req=%b we=%b addr=%h, expected 1 0 80", dmem_req, dmem_we, dmem_addr);
            end
         end
         if (c == 3) begin
            checks++;
            if (dmem_req !== 1'b0) begin
               errors++; $display("FAIL load_wait_req: dmem_req=%b, expected 0", dmem_req);
            end
         end
         if (stall === 1'b1) stall_cnt++;
         else done = 1;
         tick();
         if (!done) begin
            checks++;
            if (wb_en !== 1'b0 || mem_to_reg !== 1'b0) begin
               errors++; $display("FAIL load_bubble: cycle %0d wb_en=%b mem_to_reg=%b, expected 0 0", c, wb_en, mem_to_reg);
            end
         end
      end
      clear_inputs();
      checks++;
      if (!done || stall_cnt != 5) begin
         errors++; $display("FAIL load_stall_len: completed=%0d stall cycles=%0d, expected 1 5", done, stall_cnt);
      end
      checks++;
      if (wb_en !== 1'b1 || mem_to_reg !== 1'b1 || mem_data !== 32'h1234) begin
         errors++; $display("FAIL load_wb: wb_en=%b m2r=%b mem_data=%h, expected 1 1 1234", wb_en, mem_to_reg, mem_data);
      end
   endtask

   task automatic test_branch();
      tick();
      zero_in = 1; branch_in = 1; #1;
      checks++;
      if (pc_src !== 1'b1) begin errors++; $display("FAIL branch_taken: pc_src=%b, expected 1", pc_src); end
      zero_in = 0; #1;
      checks++;
      if (pc_src !== 1'b0) begin errors++; $display("FAIL branch_zero0: pc_src=%b, expected 0", pc_src); end
      zero_in = 1; branch_in = 0; #1;
      checks++;
      if (pc_src !== 1'b0) begin errors++; $display("FAIL branch_nobr: pc_src=%b, expected 0", pc_src); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      tick();
      mem_r_en_in = 1; wb_en_in = 1; alu_res_in = 32'h90; dest_in = 5'd4; dmem_gnt = 1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || stall !== 1'b1) begin
         errors++; $display("FAIL rmid_issue: req=%b stall=%b, expected 1 1", dmem_req, stall);
      end
      tick();
      dmem_gnt = 0;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL rmid_waitr: req=%b stall=%b, expected 0 1", dmem_req, stall);
      end
      #2 rst = 0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || wb_en !== 1'b0 || mem_to_reg !== 1'b0 ||
          alu_res !== 32'h0 || mem_data !== 32'h0 || dest !== 5'h0) begin
         errors++; $display("FAIL rmid_reset: req=%b wb_en=%b m2r=%b alu=%h mdata=%h dest=%0d, expected all 0",
                            dmem_req, wb_en, mem_to_reg, alu_res, mem_data, dest);
      end
      clear_inputs();
      tick();
      rst = 1;
      tick();
      dmem_rvalid = 1; dmem_rdata = 32'h5555AAAA;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL rmid_idle: stall=%b req=%b, expected 0 0", stall, dmem_req);
      end
      tick();
      dmem_rvalid = 0;
      checks++;
      if (wb_en !== 1'b0 || mem_to_reg !== 1'b0 || mem_data !== 32'h0) begin
         errors++; $display("FAIL rmid_late_rvalid: wb_en=%b m2r=%b mem_data=%h, expected 0 0 0",
                            wb_en, mem_to_reg, mem_data);
      end
   endtask

   // ALU, granted store, ALU on consecutive cycles with no stall
   task automatic test_back_to_back();
      tick();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         if (i == 1) begin
            mem_w_en_in = 1; alu_res_in = 32'h48; st_val_in = 32'h0BADF00D; dmem_gnt = 1;
         end else begin
            wb_en_in = 1; alu_res_in = 32'h100 * (i + 1); dest_in = 5'(i + 1);
            sb_q.push_back('{alu: 32'h100 * (i + 1), mdata: 32'h0, dest: 5'(i + 1), m2r: 1'b0});
         end
         @(negedge clk);
         checks++;
         if (stall !== 1'b0) begin
            errors++; $display("FAIL b2b_stall: slot %0d stall=%b, expected 0", i, stall);
         end
         tick();
      end
      clear_inputs();
   endtask

`ifdef MEM_MISALIGN_CHK_EN
   task automatic test_misalign();
      tick();
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL mis_pre: misalign_err=%b, expected 0", misalign_err);
      end
      mem_r_en_in = 1; wb_en_in = 1; alu_res_in = 32'h41; dest_in = 5'd6; dmem_gnt = 1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL mis_bus: req=%b stall=%b, expected 0 0", dmem_req, stall);
      end
      tick();
      clear_inputs();
      checks++;
      if (wb_en !== 1'b0 || misalign_err !== 1'b1) begin
         errors++; $display("FAIL mis_flag: wb_en=%b misalign_err=%b, expected 0 1", wb_en, misalign_err);
      end
      repeat (3) tick();
      checks++;
      if (misalign_err !== 1'b1) begin
         errors++; $display("FAIL mis_sticky: misalign_err=%b, expected 1", misalign_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_store_fast();
      test_store_wait();
      test_load_delayed();
      test_branch();
      test_reset_mid();
      test_back_to_back();
`ifdef MEM_MISALIGN_CHK_EN
      test_misalign();
`endif
      repeat (3) tick();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL sb_drain: %0d write-backs outstanding, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
